// File: rtl/song_playback_sequencer_pkg.sv
// Shared widths, note constants and FSM state encodings for the song playback sequencer.
package song_pkg;

   localparam int ADDR_W = 6;
   localparam int NOTE_W = 8;

   localparam logic [NOTE_W-1:0] NOTE_REST = '0;

   // NEXT is the one-cycle note-boundary state where the address advances or the song ends.
   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_FETCH = 3'd1,
      ST_WAIT  = 3'd2,
      ST_HOLD  = 3'd3,
      ST_NEXT  = 3'd4
   } state_e;

endpackage

// File: rtl/song_playback_sequencer_if.sv
// Song memory read port: the sequencer issues address/strobe, memory returns data one cycle later.
interface song_playback_sequencer_if;
   import song_pkg::*;

   logic              mem_rd;
   logic [ADDR_W-1:0] mem_addr;
   logic [NOTE_W-1:0] mem_data;

   modport master (output mem_rd, output mem_addr, input mem_data);
   modport slave  (input mem_rd, input mem_addr, output mem_data);

endinterface

// File: rtl/song_playback_sequencer_beat_divider.sv
// Counts tempo ticks while enabled and flags the tick that completes one note.
module beat_divider #(
   parameter int BEATS_PER_NOTE = 4
) (
   input  logic clock,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   input  logic tick,
   output logic tc
);

   localparam int CW = (BEATS_PER_NOTE > 1) ? $clog2(BEATS_PER_NOTE) : 1;
   localparam logic [CW-1:0] LAST = CW'(BEATS_PER_NOTE - 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   // Terminal count fires on the tick that would take the count past the last beat.
   always_comb begin
      tc    = enable && tick && (cnt_q == LAST);
      cnt_d = cnt_q;
      if (clear) begin
         cnt_d = '0;
      end else if (enable && tick) begin
         cnt_d = tc ? '0 : cnt_q + {{(CW-1){1'b0}}, 1'b1};
      end
   end

   // Beat counter register.
   always_ff @(posedge clock) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/song_playback_sequencer.sv
// Replays a recorded song: fetches each note from memory and holds it for a fixed number of beats.
module song_playback_sequencer
   import song_pkg::*;
#(
   parameter int BEATS_PER_NOTE = 4
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       play,
   input  logic                       stop,
   input  logic                       loop_en,
   input  logic [ADDR_W-1:0]          limit_dir,
   input  logic                       beat_tick,
   song_playback_sequencer_if.master  mem,
   output logic [NOTE_W-1:0]          note_out,
   output logic                       note_valid,
   output logic                       playing,
   output logic                       done
);

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [NOTE_W-1:0] note_q, note_d;
   logic              valid_q, valid_d;
   logic              done_q, done_d;
   logic              beat_tc;
   logic [ADDR_W:0]   addr_inc;
   logic              last_note;

   beat_divider #(
      .BEATS_PER_NOTE (BEATS_PER_NOTE)
   ) u_beat_divider (
      .clock  (clock),
      .reset  (reset),
      .clear  (state_q == ST_WAIT),
      .enable (state_q == ST_HOLD),
      .tick   (beat_tick),
      .tc     (beat_tc)
   );

   // End test is done one bit wider so a live limit at or below the address (including 0) ends the song.
   assign addr_inc  = {1'b0, addr_q} + {{ADDR_W{1'b0}}, 1'b1};
   assign last_note = (addr_inc >= {1'b0, limit_dir});

   // Next-state logic: sequence fetch/wait/hold/next, with stop overriding everything outside IDLE.
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      note_d  = note_q;
      valid_d = valid_q;
      done_d  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (play && !stop && (limit_dir != '0)) begin
               state_d = ST_FETCH;
               addr_d  = '0;
            end
         end
         ST_FETCH: begin
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            note_d  = mem.mem_data;
            valid_d = (mem.mem_data != NOTE_REST);
            state_d = ST_HOLD;
         end
         ST_HOLD: begin
            if (beat_tc) begin
               state_d = ST_NEXT;
            end
         end
         ST_NEXT: begin
            if (last_note) begin
               if (loop_en) begin
                  addr_d  = '0;
                  state_d = ST_FETCH;
               end else begin
                  state_d = ST_IDLE;
                  note_d  = NOTE_REST;
                  valid_d = 1'b0;
                  done_d  = 1'b1;
               end
            end else begin
               addr_d  = addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
               state_d = ST_FETCH;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      if (stop && (state_q != ST_IDLE)) begin
         state_d = ST_IDLE;
         note_d  = NOTE_REST;
         valid_d = 1'b0;
         done_d  = 1'b0;
      end
   end

   // State, address and note registers.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= ST_IDLE;
         addr_q  <= '0;
         note_q  <= NOTE_REST;
         valid_q <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         note_q  <= note_d;
         valid_q <= valid_d;
         done_q  <= done_d;
      end
   end

   // A stop during FETCH suppresses the read so nothing is requested on the way out.
   assign mem.mem_rd   = (state_q == ST_FETCH) && !stop;
   assign mem.mem_addr = addr_q;
   assign note_out     = note_q;
   assign note_valid   = valid_q;
   assign playing      = (state_q != ST_IDLE);
   assign done         = done_q;

endmodule

// File: tb/tb_song_playback_sequencer.sv
// Directed testbench for song_playback_sequencer (BEATS=4 instance A, BEATS=1 instance B).
module tb_song_playback_sequencer;
   import song_pkg::*;

   logic clk = 1'b0;
   logic reset, play, play_b, stop, loop_en, tick, tick_b;
   logic [ADDR_W-1:0] limit_dir;
   logic [NOTE_W-1:0] note_a, note_b;
   logic valid_a, valid_b, playing_a, playing_b, done_a, done_b;
   logic [NOTE_W-1:0] mem_a [0:(1<<ADDR_W)-1];
   logic [NOTE_W-1:0] mem_b [0:(1<<ADDR_W)-1];
   logic [NOTE_W-1:0] rdata_a, rdata_b;
   int pass_cnt = 0;
   int total_cnt = 0;

   song_playback_sequencer_if ifa ();
   song_playback_sequencer_if ifb ();

   always #5 clk = ~clk;

   song_playback_sequencer #(.BEATS_PER_NOTE(4)) dut_a (
      .clock(clk), .reset(reset), .play(play), .stop(stop), .loop_en(loop_en),
      .limit_dir(limit_dir), .beat_tick(tick), .mem(ifa.master),
      .note_out(note_a), .note_valid(valid_a), .playing(playing_a), .done(done_a));

   song_playback_sequencer #(.BEATS_PER_NOTE(1)) dut_b (
      .clock(clk), .reset(reset), .play(play_b), .stop(stop), .loop_en(loop_en),
      .limit_dir(limit_dir), .beat_tick(tick_b), .mem(ifb.master),
      .note_out(note_b), .note_valid(valid_b), .playing(playing_b), .done(done_b));

   // Registered-read song memories: data valid the cycle after the strobe.
   always @(posedge clk) begin
      if (ifa.mem_rd) rdata_a <= mem_a[ifa.mem_addr];
      if (ifb.mem_rd) rdata_b <= mem_b[ifb.mem_addr];
   end
   assign ifa.mem_data = rdata_a;
   assign ifb.mem_data = rdata_b;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic give_ticks(input int n);
      for (int i = 0; i < n; i++) begin
         tick = 1'b1; step();
         tick = 1'b0; step();
      end
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
      else begin pass_cnt++; $display("ok   %s = %0h", name, act); end
   endtask

   task automatic test_reset();
      reset = 1'b1; step(); step(); reset = 1'b0;
      chk("rst_playing", {31'd0, playing_a}, 32'd0);
      chk("rst_mem_rd", {31'd0, ifa.mem_rd}, 32'd0);
      chk("rst_addr", {26'd0, ifa.mem_addr}, 32'd0);
      chk("rst_note", {24'd0, note_a}, 32'd0);
      chk("rst_valid_done", {30'd0, valid_a, done_a}, 32'd0);
   endtask

   task automatic test_single_pass();
      logic [NOTE_W-1:0] exp_note [0:2];
      exp_note[0] = 8'h11; exp_note[1] = 8'h00; exp_note[2] = 8'h22;
      limit_dir = 6'd3; loop_en = 1'b0;
      play = 1'b1; step(); play = 1'b0;
      for (int n = 0; n < 3; n++) begin
         chk($sformatf("p_fetch_rd%0d", n), {31'd0, ifa.mem_rd}, 32'd1);
         chk($sformatf("p_fetch_addr%0d", n), {26'd0, ifa.mem_addr}, n);
         step(); step();
         chk($sformatf("p_note%0d", n), {24'd0, note_a}, {24'd0, exp_note[n]});
         chk($sformatf("p_valid%0d", n), {31'd0, valid_a}, {31'd0, exp_note[n] != 8'h00});
         give_ticks(3);
         chk($sformatf("p_held%0d", n), {24'd0, note_a, 6'd0, ifa.mem_rd, done_a},
             {24'd0, exp_note[n], 8'h00});
         give_ticks(1);
      end
      chk("p_done", {31'd0, done_a}, 32'd1);
      chk("p_playing_end", {31'd0, playing_a}, 32'd0);
      chk("p_note_clr", {23'd0, note_a, valid_a}, 32'd0);
      step();
      chk("p_done_pulse", {31'd0, done_a}, 32'd0);
   endtask

   task automatic test_loop();
      limit_dir = 6'd3; loop_en = 1'b1;
      play = 1'b1; step(); play = 1'b0;
      for (int n = 0; n < 3; n++) begin
         step(); step(); give_ticks(4);
      end
      chk("l_wrap_addr", {26'd0, ifa.mem_addr}, 32'd0);
      chk("l_wrap_rd", {31'd0, ifa.mem_rd}, 32'd1);
      chk("l_no_done", {30'd0, done_a, playing_a}, 32'd1);
      step(); step();
      chk("l_replay_note", {24'd0, note_a}, 32'h11);
      stop = 1'b1; step(); stop = 1'b0;
      chk("l_stop_idle", {29'd0, playing_a, done_a, ifa.mem_rd}, 32'd0);
      chk("l_stop_note", {24'd0, note_a}, 32'd0);
      loop_en = 1'b0;
   endtask

   task automatic test_empty_song();
      limit_dir = 6'd0;
      play = 1'b1; step(); play = 1'b0;
      chk("e_rd", {31'd0, ifa.mem_rd}, 32'd0);
      chk("e_playing", {31'd0, playing_a}, 32'd0);
      step();
      chk("e_still_idle", {30'd0, playing_a, done_a}, 32'd0);
   endtask

   task automatic test_stop_play_reset();
      limit_dir = 6'd3;
      stop = 1'b1; play = 1'b1; step(); stop = 1'b0; play = 1'b0;
      chk("sp_idle", {30'd0, playing_a, ifa.mem_rd}, 32'd0);
      play = 1'b1; step(); play = 1'b0;
      step(); step(); give_ticks(4); step(); step();
      chk("rh_addr_before", {26'd0, ifa.mem_addr}, 32'd1);
      reset = 1'b1; step(); reset = 1'b0;
      chk("rh_outputs", {22'd0, note_a, valid_a, playing_a}, 32'd0);
      chk("rh_addr", {26'd0, ifa.mem_addr}, 32'd0);
      chk("rh_rd_done", {30'd0, ifa.mem_rd, done_a}, 32'd0);
   endtask

   task automatic test_limit_shrink();
      for (int i = 0; i < 10; i++) mem_a[i] = NOTE_W'(i + 1);
      limit_dir = 6'd10;
      play = 1'b1; step(); play = 1'b0;
      for (int n = 0; n < 5; n++) begin
         step(); step(); give_ticks(4);
      end
      step(); step();
      chk("ls_note5", {24'd0, note_a}, 32'd6);
      chk("ls_addr5", {26'd0, ifa.mem_addr}, 32'd5);
      limit_dir = 6'd2;
      give_ticks(3);
      chk("ls_mid_note", {30'd0, playing_a, done_a}, 32'd2);
      give_ticks(1);
      chk("ls_done", {31'd0, done_a}, 32'd1);
      chk("ls_playing", {31'd0, playing_a}, 32'd0);
   endtask

   task automatic test_back_to_back();
      logic [NOTE_W-1:0] en;
      for (int i = 0; i < 4; i++) mem_b[i] = NOTE_W'(8'h40 + i);
      limit_dir = 6'd3; tick_b = 1'b1;
      play_b = 1'b1; step(); play_b = 1'b0;
      for (int k = 0; k < 12; k++) begin
         en = (k < 2) ? 8'h00 : NOTE_W'(8'h40 + (k - 2) / 4);
         chk($sformatf("b_rd%0d", k), {31'd0, ifb.mem_rd}, {31'd0, (k % 4) == 0});
         chk($sformatf("b_addr%0d", k), {26'd0, ifb.mem_addr}, k / 4);
         chk($sformatf("b_note%0d", k), {24'd0, note_b}, {24'd0, en});
         step();
      end
      chk("b_done", {30'd0, done_b, playing_b}, 32'd2);
      step();
      chk("b_done_pulse", {31'd0, done_b}, 32'd0);
      tick_b = 1'b0;
   endtask

   initial begin
      reset = 1'b0; play = 1'b0; play_b = 1'b0; stop = 1'b0; loop_en = 1'b0;
      tick = 1'b0; tick_b = 1'b0; limit_dir = '0;
      for (int i = 0; i < (1 << ADDR_W); i++) begin
         mem_a[i] = 8'hEE; mem_b[i] = 8'hEE;
      end
      mem_a[0] = 8'h11; mem_a[1] = 8'h00; mem_a[2] = 8'h22;
      test_reset();
      test_single_pass();
      test_loop();
      test_empty_song();
      test_stop_play_reset();
      test_limit_shrink();
      test_back_to_back();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
